// File: rtl/writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_pkg
// Description : Shared definitions for the writeback stage: data widths,
//               opcode constants, N/Z/P condition-code encodings, FSM states
//               and the register-writing opcode decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_pkg;

  localparam int PC_WIDTH     = 16;
  localparam int OPCODE_WIDTH = 8;
  localparam int REG_WIDTH    = 16;

  // Opcode encodings shared with the rest of the pipeline
  localparam logic [OPCODE_WIDTH-1:0] ADD_D  = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] ADDI_D = 8'h02;
  localparam logic [OPCODE_WIDTH-1:0] AND_D  = 8'h03;
  localparam logic [OPCODE_WIDTH-1:0] ANDI_D = 8'h04;
  localparam logic [OPCODE_WIDTH-1:0] MOV    = 8'h05;
  localparam logic [OPCODE_WIDTH-1:0] MOVI_D = 8'h06;
  localparam logic [OPCODE_WIDTH-1:0] LDW    = 8'h07;
  localparam logic [OPCODE_WIDTH-1:0] STW    = 8'h08;
  localparam logic [OPCODE_WIDTH-1:0] BRN    = 8'h09;
  localparam logic [OPCODE_WIDTH-1:0] BRZ    = 8'h0A;
  localparam logic [OPCODE_WIDTH-1:0] BRP    = 8'h0B;
  localparam logic [OPCODE_WIDTH-1:0] JMP    = 8'h0C;
  localparam logic [OPCODE_WIDTH-1:0] JSR    = 8'h0D;
  localparam logic [OPCODE_WIDTH-1:0] JSRR   = 8'h0E;

  // Condition-code encodings {N,Z,P}
  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  // Writeback FSM state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_t;

  // True for opcodes that commit a result to the register file
  function automatic logic wb_writes_reg(input logic [OPCODE_WIDTH-1:0] op);
    logic w_hit;
    w_hit = 1'b0;
    case (op)
      ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D, LDW: w_hit = 1'b1;
      default:                                        w_hit = 1'b0;
    endcase
    return w_hit;
  endfunction

endpackage : writeback_pkg
`default_nettype wire

// File: rtl/wb_ccgen.sv
`default_nettype none
// ============================================================================
// Module      : wb_ccgen
// Description : Combinational N/Z/P condition-code derivation from a
//               register-width data word (sign bit first, then zero test).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ccgen
  import writeback_pkg::*;
(
  input  logic [REG_WIDTH-1:0] data,
  output logic [2:0]           cc
);

  // Negative wins over zero; anything else is positive
  always_comb begin
    cc = CC_P;
    if (data[REG_WIDTH-1])
      cc = CC_N;
    else if (data == '0)
      cc = CC_Z;
  end

endmodule : wb_ccgen
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module      : writeback
// Description : Writeback pipeline stage. Commits ALU/load results to the
//               decode register file on the falling clock edge so decode can
//               consume them on the following rising edge, and tracks the
//               last committed N/Z/P flags.
//               Optional macro WB_STATS_EN adds 32-bit retired-instruction
//               and squashed-slot counters.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback
  import writeback_pkg::*;
(
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [REG_WIDTH-1:0]    I_MemOut,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  output logic                    O_WriteBackEnable,
  output logic [3:0]              O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]    O_WriteBackData,
  output logic [2:0]              O_CondCode,
  output logic                    O_LOCK
`ifdef WB_STATS_EN
  ,
  output logic [31:0]             O_RetireCount,
  output logic [31:0]             O_BubbleCount
`endif
);

  wb_state_t              r_state;
  logic                   w_valid;
  logic                   w_bubble;
  logic                   w_write;
  logic [REG_WIDTH-1:0]   w_wb_data;
  logic [2:0]             w_cc;

  // PC is carried for debug visibility only; it never affects the result
  logic w_unused_pc;
  assign w_unused_pc = ^I_PC;

  // Slot qualification: a running pipeline with no bubble of either kind
  always_comb begin
    w_valid   = I_LOCK & ~I_FetchStall & ~I_DepStall;
    w_bubble  = I_LOCK & (I_FetchStall | I_DepStall);
    w_write   = w_valid & wb_writes_reg(I_Opcode);
    w_wb_data = (I_Opcode == LDW) ? I_MemOut : I_ALUOut;
  end

  wb_ccgen u_ccgen (
    .data (w_wb_data),
    .cc   (w_cc)
  );

  // Stage FSM and registered outputs; enable is a single-cycle pulse and
  // index/data/flags only move on a real write
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_state           <= ST_IDLE;
      O_WriteBackEnable <= 1'b0;
      O_WriteBackRegIdx <= 4'd0;
      O_WriteBackData   <= '0;
      O_CondCode        <= CC_Z;
      O_LOCK            <= 1'b0;
    end else begin
      O_LOCK <= I_LOCK;
      case (r_state)
        ST_IDLE: if (I_LOCK)  r_state <= ST_RUN;
        ST_RUN:  if (!I_LOCK) r_state <= ST_IDLE;
        default:              r_state <= ST_IDLE;
      endcase
      // A slot arriving with I_LOCK low is never valid, which squashes
      // the RUN->IDLE slot and keeps enable low throughout IDLE
      O_WriteBackEnable <= w_write;
      if (w_write) begin
        O_WriteBackRegIdx <= I_DestRegIdx;
        O_WriteBackData   <= w_wb_data;
        O_CondCode        <= w_cc;
      end
    end
  end

`ifdef WB_STATS_EN
  // Free-running wrap-around statistics counters
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_RetireCount <= 32'd0;
      O_BubbleCount <= 32'd0;
    end else begin
      if (w_valid)  O_RetireCount <= O_RetireCount + 32'd1;
      if (w_bubble) O_BubbleCount <= O_BubbleCount + 32'd1;
    end
  end
`endif

endmodule : writeback
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback
// Description : Directed self-checking bench for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback;
  import writeback_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    lock;
  logic [PC_WIDTH-1:0]     pc;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [3:0]              dest;
  logic [REG_WIDTH-1:0]    alu;
  logic [REG_WIDTH-1:0]    mem;
  logic                    fstall;
  logic                    dstall;
  logic                    wb_en;
  logic [3:0]              wb_idx;
  logic [REG_WIDTH-1:0]    wb_data;
  logic [2:0]              cc;
  logic                    lock_o;
`ifdef WB_STATS_EN
  logic [31:0]             retire_cnt;
  logic [31:0]             bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  writeback dut (
    .I_CLOCK           (clk),
    .I_RESET_N         (rst_n),
    .I_LOCK            (lock),
    .I_PC              (pc),
    .I_Opcode          (opcode),
    .I_DestRegIdx      (dest),
    .I_ALUOut          (alu),
    .I_MemOut          (mem),
    .I_FetchStall      (fstall),
    .I_DepStall        (dstall),
    .O_WriteBackEnable (wb_en),
    .O_WriteBackRegIdx (wb_idx),
    .O_WriteBackData   (wb_data),
    .O_CondCode        (cc),
    .O_LOCK            (lock_o)
`ifdef WB_STATS_EN
    ,
    .O_RetireCount     (retire_cnt),
    .O_BubbleCount     (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one slot after a rising edge, let the falling edge take it,
  // and return 1 time unit after that falling edge
  task automatic slot(input logic l, input logic [OPCODE_WIDTH-1:0] op,
                      input logic [3:0] d, input logic [REG_WIDTH-1:0] a,
                      input logic [REG_WIDTH-1:0] m, input logic fs,
                      input logic ds);
    @(posedge clk);
    lock = l; opcode = op; dest = d; alu = a; mem = m;
    fstall = fs; dstall = ds; pc = pc + 16'd2;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b0; pc = '0; opcode = STW; dest = 4'd0;
    alu = '0; mem = '0; fstall = 1'b0; dstall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wb_en !== 1'b0)   begin failures++; $display("FAIL reset_en got=%b exp=0", wb_en); end
    checks++; if (wb_idx !== 4'd0)  begin failures++; $display("FAIL reset_idx got=%h exp=0", wb_idx); end
    checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", wb_data); end
    checks++; if (cc !== 3'b010)    begin failures++; $display("FAIL reset_cc got=%b exp=010", cc); end
    checks++; if (lock_o !== 1'b0)  begin failures++; $display("FAIL reset_lock got=%b exp=0", lock_o); end
    @(posedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    slot(1'b1, ADD_D, 4'd3, 16'h0005, 16'hAAAA, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b1)    begin failures++; $display("FAIL add_en got=%b exp=1", wb_en); end
    checks++; if (wb_idx !== 4'd3)   begin failures++; $display("FAIL add_idx got=%h exp=3", wb_idx); end
    checks++; if (wb_data !== 16'h0005) begin failures++; $display("FAIL add_data got=%h exp=0005", wb_data); end
    checks++; if (cc !== 3'b001)     begin failures++; $display("FAIL add_cc got=%b exp=001", cc); end
    checks++; if (lock_o !== 1'b1)   begin failures++; $display("FAIL add_lock got=%b exp=1", lock_o); end
    // fetch bubble: pulse ends, index/data/flags hold
    slot(1'b1, ADD_D, 4'd9, 16'h8888, 16'h0, 1'b1, 1'b0);
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL add_pulse_end got=%b exp=0", wb_en); end
    checks++; if (wb_idx !== 4'd3)   begin failures++; $display("FAIL add_idx_hold got=%h exp=3", wb_idx); end
    checks++; if (wb_data !== 16'h0005) begin failures++; $display("FAIL add_data_hold got=%h exp=0005", wb_data); end
    checks++; if (cc !== 3'b001)     begin failures++; $display("FAIL add_cc_hold got=%b exp=001", cc); end
  endtask

  task automatic test_ldw();
    slot(1'b1, LDW, 4'd2, 16'h1234, 16'h8001, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b1)    begin failures++; $display("FAIL ldw_en got=%b exp=1", wb_en); end
    checks++; if (wb_idx !== 4'd2)   begin failures++; $display("FAIL ldw_idx got=%h exp=2", wb_idx); end
    checks++; if (wb_data !== 16'h8001) begin failures++; $display("FAIL ldw_data got=%h exp=8001", wb_data); end
    checks++; if (cc !== 3'b100)     begin failures++; $display("FAIL ldw_cc got=%b exp=100", cc); end
  endtask

  task automatic test_nowrite();
    slot(1'b1, STW, 4'd7, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL stw_en got=%b exp=0", wb_en); end
    checks++; if (cc !== 3'b100)     begin failures++; $display("FAIL stw_cc got=%b exp=100", cc); end
    checks++; if (wb_data !== 16'h8001) begin failures++; $display("FAIL stw_data_hold got=%h exp=8001", wb_data); end
    slot(1'b1, ADD_D, 4'd6, 16'h0001, 16'h0000, 1'b0, 1'b1);
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL depstall_en got=%b exp=0", wb_en); end
    checks++; if (wb_idx !== 4'd2)   begin failures++; $display("FAIL depstall_idx got=%h exp=2", wb_idx); end
    slot(1'b1, BRZ, 4'd5, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL brz_en got=%b exp=0", wb_en); end
    checks++; if (cc !== 3'b100)     begin failures++; $display("FAIL brz_cc got=%b exp=100", cc); end
    slot(1'b1, JSRR, 4'd5, 16'h0003, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL jsrr_en got=%b exp=0", wb_en); end
  endtask

  task automatic test_back_to_back();
    slot(1'b1, MOVI_D, 4'd1, 16'h0000, 16'h5555, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b1)    begin failures++; $display("FAIL b2b0_en got=%b exp=1", wb_en); end
    checks++; if (wb_idx !== 4'd1)   begin failures++; $display("FAIL b2b0_idx got=%h exp=1", wb_idx); end
    checks++; if (wb_data !== 16'h0000) begin failures++; $display("FAIL b2b0_data got=%h exp=0000", wb_data); end
    checks++; if (cc !== 3'b010)     begin failures++; $display("FAIL b2b0_cc got=%b exp=010", cc); end
    slot(1'b1, ADDI_D, 4'd1, 16'h0007, 16'h5555, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b1)    begin failures++; $display("FAIL b2b1_en got=%b exp=1", wb_en); end
    checks++; if (wb_data !== 16'h0007) begin failures++; $display("FAIL b2b1_data got=%h exp=0007", wb_data); end
    checks++; if (cc !== 3'b001)     begin failures++; $display("FAIL b2b1_cc got=%b exp=001", cc); end
    slot(1'b1, MOV, 4'd8, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_idx !== 4'd8)   begin failures++; $display("FAIL mov_idx got=%h exp=8", wb_idx); end
    checks++; if (cc !== 3'b100)     begin failures++; $display("FAIL mov_cc got=%b exp=100", cc); end
  endtask

  task automatic test_idle();
    // lock drops: RUN->IDLE slot squashed even though it is a writer
    slot(1'b0, AND_D, 4'd4, 16'h0010, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL idle_en got=%b exp=0", wb_en); end
    checks++; if (lock_o !== 1'b0)   begin failures++; $display("FAIL idle_lock got=%b exp=0", lock_o); end
    checks++; if (cc !== 3'b100)     begin failures++; $display("FAIL idle_cc got=%b exp=100", cc); end
    checks++; if (wb_data !== 16'hFFFF) begin failures++; $display("FAIL idle_data got=%h exp=FFFF", wb_data); end
    slot(1'b0, ANDI_D, 4'd4, 16'h0010, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL idle2_en got=%b exp=0", wb_en); end
    // relock: first slot back in RUN writes
    slot(1'b1, ANDI_D, 4'd4, 16'h0010, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b1)    begin failures++; $display("FAIL relock_en got=%b exp=1", wb_en); end
    checks++; if (wb_data !== 16'h0010) begin failures++; $display("FAIL relock_data got=%h exp=0010", wb_data); end
  endtask

  task automatic test_reset_midpulse();
    slot(1'b1, ADD_D, 4'd5, 16'h8000, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b1)    begin failures++; $display("FAIL mid_pre_en got=%b exp=1", wb_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL mid_en got=%b exp=0", wb_en); end
    checks++; if (wb_idx !== 4'd0)   begin failures++; $display("FAIL mid_idx got=%h exp=0", wb_idx); end
    checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL mid_data got=%h exp=0000", wb_data); end
    checks++; if (cc !== 3'b010)     begin failures++; $display("FAIL mid_cc got=%b exp=010", cc); end
    checks++; if (lock_o !== 1'b0)   begin failures++; $display("FAIL mid_lock got=%b exp=0", lock_o); end
    lock = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (wb_en !== 1'b0)    begin failures++; $display("FAIL mid_noreplay got=%b exp=0", wb_en); end
    slot(1'b1, AND_D, 4'd4, 16'h00F0, 16'h0000, 1'b0, 1'b0);
    checks++; if (wb_en !== 1'b1)    begin failures++; $display("FAIL post_en got=%b exp=1", wb_en); end
    checks++; if (wb_idx !== 4'd4)   begin failures++; $display("FAIL post_idx got=%h exp=4", wb_idx); end
    checks++; if (wb_data !== 16'h00F0) begin failures++; $display("FAIL post_data got=%h exp=00F0", wb_data); end
    checks++; if (cc !== 3'b001)     begin failures++; $display("FAIL post_cc got=%b exp=001", cc); end
  endtask

`ifdef WB_STATS_EN
  task automatic test_stats();
    @(posedge clk);
    rst_n = 1'b0; lock = 1'b0;
    #1;
    checks++; if (retire_cnt !== 32'd0) begin failures++; $display("FAIL stats_rst_ret got=%0d exp=0", retire_cnt); end
    checks++; if (bubble_cnt !== 32'd0) begin failures++; $display("FAIL stats_rst_bub got=%0d exp=0", bubble_cnt); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      slot(1'b1, (i % 2 == 0) ? ADD_D : STW, 4'(i), 16'(i), 16'h0, 1'b0, 1'b0);
      if (i == 2) slot(1'b1, ADD_D, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      if (i == 5) slot(1'b1, ADD_D, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (i == 7) slot(1'b1, ADD_D, 4'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    end
    slot(1'b0, ADD_D, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    checks++; if (retire_cnt !== 32'd10) begin failures++; $display("FAIL stats_ret got=%0d exp=10", retire_cnt); end
    checks++; if (bubble_cnt !== 32'd3)  begin failures++; $display("FAIL stats_bub got=%0d exp=3", bubble_cnt); end
    @(posedge clk);
    force dut.O_RetireCount = 32'hFFFF_FFFF;
    #1;
    release dut.O_RetireCount;
    slot(1'b1, ADD_D, 4'd1, 16'h1, 16'h0, 1'b0, 1'b0);
    checks++; if (retire_cnt !== 32'd0) begin failures++; $display("FAIL stats_wrap got=%h exp=00000000", retire_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_ldw();
    test_nowrite();
    test_back_to_back();
    test_idle();
    test_reset_midpulse();
`ifdef WB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_writeback
`default_nettype wire
